// File: rtl/csr_machine_unit_pkg.sv
// csr_machine_unit_pkg: shared CSR addresses, cause codes, encodings and helpers
package csr_machine_unit_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MISA = 12'h301;
  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam logic [11:0] CSR_MIP = 12'h344;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHPM = 12'hB03;
  localparam logic [11:0] CSR_HI_OFS = 12'h080;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID = 12'hF12;
  localparam logic [11:0] CSR_MIMPID = 12'hF13;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;
  localparam logic [31:0] MISA_VAL = 32'h4000_1100;
  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;
  localparam logic [4:0] CAUSE_LOCAL = 5'd16;
  typedef enum logic [1:0] {WOP_NOP, WOP_WRITE, WOP_SET, WOP_CLEAR} wop_e;
  typedef enum logic {ST_RUN, ST_WAIT} wfi_state_e;
  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;
  localparam mstatus_t MSTATUS_INIT = '{mpie: 1'b0, mie: 1'b0};
  typedef struct packed {
    logic [15:0] lcl;
    logic [3:0] rsv3;
    logic meip;
    logic [2:0] rsv2;
    logic mtip;
    logic [2:0] rsv1;
    logic msip;
    logic [2:0] rsv0;
  } irq_t;
  function automatic logic [31:0] mstatus_rd(mstatus_t s);
    return {19'b0, 2'b11, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
  endfunction
  function automatic logic [31:0] wop_apply(wop_e op, logic [31:0] old, logic [31:0] src);
    return op == WOP_WRITE ? src : op == WOP_SET ? old | src : op == WOP_CLEAR ? old & ~src : old;
  endfunction
  function automatic logic [11:0] cnt_addr(int k);
    return k == 0 ? CSR_MCYCLE : k == 1 ? CSR_MINSTRET : CSR_MHPM + 12'(k - 2);
  endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: wide event counter with inhibit and independently writable 32-bit halves
module csr_counter #(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        inh,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);
  logic [W-1:0] cnt;
  logic [63:0] ext;
  assign ext = 64'(cnt);
  assign lo = ext[31:0];
  assign hi = ext[63:32];
  // a half write replaces the whole cycle's update; otherwise count unless inhibited
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (wr_lo) cnt <= W'({ext[63:32], wdata});
    else if (wr_hi) cnt <= W'({wdata, ext[31:0]});
    else if (inc && !inh) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/csr_machine_unit.sv
// csr_machine_unit: machine-mode CSR file, counters, trap controller and WFI stall FSM
module csr_machine_unit
  import csr_machine_unit_pkg::*;
#(
  parameter int          NUM_LOCAL   = 4,
  parameter int          NUM_HPM     = 2,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [11:0]          raddr,
  output logic [31:0]          rdata,
  output logic                 illegal,
  input  logic                 wr_en,
  input  logic [11:0]          waddr,
  input  logic [1:0]           wop,
  input  logic [31:0]          wsrc,
  input  logic                 retire,
  input  logic [NUM_HPM-1:0]   hpm_event,
  input  logic                 exc_valid,
  input  logic [3:0]           exc_cause,
  input  logic [31:0]          exc_epc,
  input  logic [31:0]          exc_tval,
  input  logic [31:0]          irq_epc,
  input  logic                 mret,
  input  logic                 wfi,
  input  logic                 ext_irpt,
  input  logic                 timer_irpt,
  input  logic                 soft_irpt,
  input  logic [NUM_LOCAL-1:0] local_irpt,
  output logic                 trap,
  output logic [31:0]          trap_pc,
  output logic                 mret_out,
  output logic [31:0]          mepc_out,
  output logic                 stall
);
  localparam int NC = 2 + NUM_HPM;
  localparam logic [31:0] MIE_MASK = 32'h888 | 32'(((64'd1 << NUM_LOCAL) - 64'd1) << 16);
  localparam logic [31:0] INH_MASK = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
  mstatus_t mst;
  irq_t mie_q, mip_q;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval, minh;
  logic [31:0] cnt_lo [NC];
  logic [31:0] cnt_hi [NC];
  logic [NC-1:0] cnt_inc;
  wfi_state_e state;
  logic [32:0] rd_r, wr_r;
  logic [31:0] wnew, en_pend, pend, tbase, tpc;
  logic [4:0] icause;
  logic we, take, take_irq;
  wop_e op;
  function automatic logic [32:0] csr_read(logic [11:0] a);
    logic [32:0] r;
    r = {1'b1, 32'b0};
    case (a)
      CSR_MSTATUS: r[31:0] = mstatus_rd(mst);
      CSR_MISA: r[31:0] = MISA_VAL;
      CSR_MIE: r[31:0] = mie_q;
      CSR_MIP: r[31:0] = mip_q;
      CSR_MTVEC: r[31:0] = mtvec;
      CSR_MCOUNTINHIBIT: r[31:0] = minh;
      CSR_MSCRATCH: r[31:0] = mscratch;
      CSR_MEPC: r[31:0] = mepc;
      CSR_MCAUSE: r[31:0] = mcause;
      CSR_MTVAL: r[31:0] = mtval;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: r[31:0] = '0;
      default: r[32] = 1'b0;
    endcase
    for (int k = 0; k < NC; k++) begin
      if (a == cnt_addr(k)) r = {1'b1, cnt_lo[k]};
      if (a == cnt_addr(k) + CSR_HI_OFS) r = {1'b1, cnt_hi[k]};
    end
    return r;
  endfunction
  assign rd_r = csr_read(raddr);
  assign wr_r = csr_read(waddr);
  // read port, illegal-access detect and write-operand formation
  always_comb begin
    rdata = rd_en ? rd_r[31:0] : '0;
    illegal = (rd_en && !rd_r[32]) || (wr_en && waddr[11:10] == 2'b11);
    op = wop_e'(wop);
    wnew = wop_apply(op, wr_r[31:0], wsrc);
    we = wr_en && wr_r[32] && waddr[11:10] != 2'b11 && (op == WOP_WRITE || (op != WOP_NOP && wsrc != '0));
  end
  // interrupt arbitration: MEI > MSI > MTI > lowest-index local line
  always_comb begin
    en_pend = mie_q & mip_q;
    pend = mst.mie ? en_pend : '0;
    icause = CAUSE_MEI;
    for (int i = NUM_LOCAL - 1; i >= 0; i--) icause = pend[16 + i] ? CAUSE_LOCAL + 5'(i) : icause;
    icause = pend[CAUSE_MTI] ? CAUSE_MTI : icause;
    icause = pend[CAUSE_MSI] ? CAUSE_MSI : icause;
    icause = pend[CAUSE_MEI] ? CAUSE_MEI : icause;
    take_irq = !exc_valid && pend != '0;
    take = exc_valid || take_irq;
    tbase = {mtvec[31:2], 2'b00};
    tpc = take_irq && mtvec[1:0] == 2'b01 ? tbase + {25'b0, icause, 2'b00} : tbase;
  end
  assign cnt_inc = {hpm_event, retire, 1'b1};
  assign mepc_out = mepc;
  for (genvar c = 0; c < NC; c++) begin : g_cnt
    localparam int IB = c == 0 ? 0 : c == 1 ? 2 : c + 1;
    csr_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[c]),
      .inh   (minh[IB]),
      .wr_lo (we && waddr == cnt_addr(c)),
      .wr_hi (we && waddr == cnt_addr(c) + CSR_HI_OFS),
      .wdata (wnew),
      .lo    (cnt_lo[c]),
      .hi    (cnt_hi[c])
    );
  end
  // CSR state and trap/mret sequencing; trap updates override same-cycle software writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mst <= MSTATUS_INIT;
      mie_q <= '0;
      mip_q <= '0;
      mtvec <= MTVEC_RESET;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
      minh <= '0;
      trap <= 1'b0;
      trap_pc <= '0;
      mret_out <= 1'b0;
    end else begin
      mip_q <= irq_t'({16'(local_irpt), 4'b0, ext_irpt, 3'b0, timer_irpt, 3'b0, soft_irpt, 3'b0});
      if (we && waddr == CSR_MSTATUS) mst <= '{mpie: wnew[7], mie: wnew[3]};
      if (we && waddr == CSR_MIE) mie_q <= irq_t'(wnew & MIE_MASK);
      if (we && waddr == CSR_MTVEC) mtvec <= wnew;
      if (we && waddr == CSR_MSCRATCH) mscratch <= wnew;
      if (we && waddr == CSR_MEPC) mepc <= wnew & ~32'h3;
      if (we && waddr == CSR_MCAUSE) mcause <= wnew;
      if (we && waddr == CSR_MTVAL) mtval <= wnew;
      if (we && waddr == CSR_MCOUNTINHIBIT) minh <= wnew & INH_MASK;
      trap <= take;
      mret_out <= mret && !take;
      if (take) begin
        mst <= '{mpie: mst.mie, mie: 1'b0};
        mcause <= exc_valid ? {28'b0, exc_cause} : {1'b1, 26'b0, icause};
        mepc <= (exc_valid ? exc_epc : irq_epc) & ~32'h3;
        mtval <= exc_valid ? exc_tval : '0;
        trap_pc <= tpc;
      end else if (mret) mst <= '{mpie: 1'b1, mie: mst.mpie};
    end
  end
  // WFI stall FSM: sleep while no enabled interrupt is pending, wake regardless of MIE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      stall <= 1'b0;
    end else if (state == ST_RUN && wfi && en_pend == '0) begin
      state <= ST_WAIT;
      stall <= 1'b1;
    end else if (state == ST_WAIT && en_pend != '0) begin
      state <= ST_RUN;
      stall <= 1'b0;
    end
  end
endmodule

// File: tb/tb_csr_machine_unit.sv
// tb_csr_machine_unit: randomized and directed self-checking bench for csr_machine_unit
module tb_csr_machine_unit;
  localparam int NL = 4;
  localparam int NH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic rd_en = 0, wr_en = 0, retire = 0, exc_valid = 0, mret = 0, wfi = 0;
  logic ext_irpt = 0, timer_irpt = 0, soft_irpt = 0;
  logic [11:0] raddr = 0, waddr = 0;
  logic [1:0] wop = 0;
  logic [31:0] wsrc = 0, exc_epc = 0, exc_tval = 0, irq_epc = 0;
  logic [3:0] exc_cause = 0;
  logic [NH-1:0] hpm_event = 0;
  logic [NL-1:0] local_irpt = 0;
  logic [31:0] rdata, trap_pc, mepc_out;
  logic illegal, trap, mret_out, stall;
  int checks = 0, errors = 0;

  csr_machine_unit #(.NUM_LOCAL(NL), .NUM_HPM(NH), .CNT_WIDTH(64), .MTVEC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .illegal(illegal),
    .wr_en(wr_en), .waddr(waddr), .wop(wop), .wsrc(wsrc), .retire(retire), .hpm_event(hpm_event),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_epc(exc_epc), .exc_tval(exc_tval),
    .irq_epc(irq_epc), .mret(mret), .wfi(wfi), .ext_irpt(ext_irpt), .timer_irpt(timer_irpt),
    .soft_irpt(soft_irpt), .local_irpt(local_irpt), .trap(trap), .trap_pc(trap_pc),
    .mret_out(mret_out), .mepc_out(mepc_out), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic csr_wr(logic [11:0] a, logic [1:0] o, logic [31:0] s);
    wr_en = 1; waddr = a; wop = o; wsrc = s;
    @(negedge clk);
    wr_en = 0; wop = 0;
  endtask

  task automatic csr_rd(logic [11:0] a, output logic [31:0] d, output logic ill);
    rd_en = 1; raddr = a;
    #1;
    d = rdata; ill = illegal;
    rd_en = 0;
  endtask

  task automatic rd_check(string tag, logic [11:0] a, logic [31:0] exp);
    logic [31:0] d;
    logic ill;
    csr_rd(a, d, ill);
    check(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ra [6] = '{12'h340, 12'h305, 12'h304, 12'h343, 12'h342, 12'h341};
    logic [31:0] rm [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h000F_0888, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    logic [31:0] rv [6] = '{default: 32'h0};
    logic [31:0] d, c0, r0, h0;
    logic ill;
    int k, e;
    tick(3);
    rst = 0;
    // reset state
    check("trap_rst", trap, 0);
    check("trap_pc_rst", trap_pc, 0);
    check("mret_out_rst", mret_out, 0);
    check("stall_rst", stall, 0);
    check("mepc_out_rst", mepc_out, 0);
    rd_check("mstatus_rst", 12'h300, 32'h1800);
    rd_check("mtvec_rst", 12'h305, 32'h0);
    rd_check("mcycle_rst", 12'hB00, 32'h0);
    rd_check("minstret_rst", 12'hB02, 32'h0);
    // constants and illegal accesses
    csr_rd(12'h301, d, ill);
    check("misa", d, 32'h4000_1100);
    check("misa_legal", ill, 0);
    csr_rd(12'h7C0, d, ill);
    check("unimpl_rdata", d, 0);
    check("unimpl_illegal", ill, 1);
    csr_rd(12'hB05, d, ill);
    check("hpm5_illegal", ill, 1);
    rd_check("mhartid", 12'hF14, 32'h0);
    raddr = 12'h301; rd_en = 0; #1;
    check("rdata_idle", rdata, 0);
    wr_en = 1; waddr = 12'hF14; wop = 1; wsrc = 32'h5; #1;
    check("wr_ro_illegal", illegal, 1);
    wr_en = 0; wop = 0;
    tick();
    // randomized read-modify-write against an abstract register model
    for (int n = 0; n < 40; n++) begin
      int i, j;
      logic [1:0] o;
      logic [31:0] s;
      i = $urandom_range(0, 5);
      o = 2'($urandom_range(0, 3));
      s = $urandom;
      if ($urandom_range(0, 5) == 0) s = 0;
      csr_wr(ra[i], o, s);
      if (o == 1) rv[i] = s & rm[i];
      else if (o == 2) rv[i] = (rv[i] | s) & rm[i];
      else if (o == 3) rv[i] = rv[i] & ~s;
      j = $urandom_range(0, 5);
      rd_check($sformatf("rand_%03h", ra[j]), ra[j], rv[j]);
    end
    check("mepc_out_rand", mepc_out, rv[5]);
    // mie set / clear
    csr_wr(12'h304, 1, 32'h888);
    csr_wr(12'h304, 2, 32'h10000);
    rd_check("mie_set", 12'h304, 32'h10888);
    csr_wr(12'h304, 3, 32'h8);
    rd_check("mie_clear", 12'h304, 32'h10880);
    // vectored interrupt: MEI beats MTI
    csr_wr(12'h304, 1, 32'h880);
    csr_wr(12'h305, 1, 32'h101);
    csr_wr(12'h300, 1, 32'h0);
    irq_epc = 32'h200; ext_irpt = 1; timer_irpt = 1;
    tick();
    csr_wr(12'h300, 2, 32'h8);
    check("trap_not_early", trap, 0);
    tick();
    check("irq_trap", trap, 1);
    check("irq_trap_pc", trap_pc, 32'h12C);
    check("irq_mepc", mepc_out, 32'h200);
    rd_check("irq_mcause", 12'h342, 32'h8000_000B);
    rd_check("irq_mstatus", 12'h300, 32'h1880);
    rd_check("irq_mtval", 12'h343, 32'h0);
    tick();
    check("trap_pulse", trap, 0);
    // exception beats pending interrupt, then mret
    csr_wr(12'h300, 2, 32'h8);
    exc_valid = 1; exc_cause = 2; exc_epc = 32'h80; exc_tval = 32'h55;
    tick();
    exc_valid = 0; ext_irpt = 0; timer_irpt = 0;
    check("exc_trap", trap, 1);
    check("exc_trap_pc", trap_pc, 32'h100);
    check("exc_mepc", mepc_out, 32'h80);
    rd_check("exc_mcause", 12'h342, 32'h2);
    rd_check("exc_mtval", 12'h343, 32'h55);
    rd_check("exc_mstatus", 12'h300, 32'h1880);
    tick(2);
    mret = 1;
    tick();
    mret = 0;
    check("mret_out", mret_out, 1);
    check("mret_no_trap", trap, 0);
    rd_check("mret_mstatus", 12'h300, 32'h1888);
    tick();
    check("mret_pulse", mret_out, 0);
    // counters and inhibit
    csr_wr(12'h320, 1, 32'hFFFF_FFFF);
    rd_check("minh_mask", 12'h320, 32'h1D);
    csr_wr(12'h320, 1, 32'h1);
    csr_rd(12'hB00, c0, ill);
    csr_rd(12'hB02, r0, ill);
    csr_rd(12'hB03, h0, ill);
    k = 0; e = 0;
    for (int n = 0; n < 10; n++) begin
      retire = 1'($urandom_range(0, 1));
      hpm_event = NH'($urandom_range(0, 3));
      k += int'(retire);
      e += int'(hpm_event[0]);
      tick();
    end
    retire = 0; hpm_event = 0;
    rd_check("mcycle_inhibit", 12'hB00, c0);
    rd_check("minstret_count", 12'hB02, r0 + 32'(k));
    rd_check("hpm3_count", 12'hB03, h0 + 32'(e));
    csr_wr(12'hB80, 1, 32'h0);
    csr_wr(12'hB00, 1, 32'hFFFF_FFFF);
    csr_wr(12'h320, 3, 32'h1);
    rd_check("mcycle_pre", 12'hB00, 32'hFFFF_FFFF);
    rd_check("mcycleh_pre", 12'hB80, 32'h0);
    tick();
    rd_check("mcycle_carry", 12'hB00, 32'h0);
    rd_check("mcycleh_carry", 12'hB80, 32'h1);
    csr_wr(12'hB00, 1, 32'h100);
    rd_check("mcycle_override", 12'hB00, 32'h100);
    rd_check("mcycleh_keep", 12'hB80, 32'h1);
    csr_wr(12'h320, 2, 32'h1);
    csr_wr(12'hB00, 1, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 1, 32'hFFFF_FFFF);
    csr_wr(12'h320, 3, 32'h1);
    rd_check("mcycleh_full", 12'hB80, 32'hFFFF_FFFF);
    tick();
    rd_check("mcycle_wrap", 12'hB00, 32'h0);
    rd_check("mcycleh_wrap", 12'hB80, 32'h0);
    // WFI sleep and wake on a local interrupt with MIE clear
    csr_wr(12'h300, 3, 32'h8);
    csr_wr(12'h304, 1, 32'h40000);
    wfi = 1;
    tick();
    wfi = 0;
    check("wfi_stall", stall, 1);
    tick(3);
    check("wfi_hold", stall, 1);
    local_irpt = 4'b0100;
    tick();
    check("wake_latch_stall", stall, 1);
    check("wake_no_trap0", trap, 0);
    tick();
    check("wake_stall", stall, 0);
    check("wake_no_trap1", trap, 0);
    wfi = 1;
    tick();
    wfi = 0;
    check("wfi_pending_run", stall, 0);
    local_irpt = 0;
    tick();
    wfi = 1;
    tick();
    wfi = 0;
    check("wfi_stall2", stall, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_in_wait", stall, 0);
    rd_check("mie_after_rst", 12'h304, 32'h0);
    rd_check("mstatus_after_rst", 12'h300, 32'h1800);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
